prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory stage directly upstream of `cpu`. It holds the CPU in reset while a program is shifted in one bit at a time over a valid/ready serial port. It then releases the CPU and serves instruction words combinationally on `data` for the CPU's `addr`. A program can be reloaded at any time; the CPU is re-held in reset until the reload completes.

## Interface
- `ADDR_W`, 1, instruction address width; depth `N = 2**ADDR_W` words
- `DATA_W`, 1, instruction word width
- `clk`  in  1  system clock, all state on rising edge
- `n_rst`  in  1  reset, synchronous, active-low (sampled on `clk` rising edge)
- `ser_valid`  in  1  serial bit present
- `ser_bit`  in  1  serial program bit, LSB of each word first, word 0 first
- `ser_ready`  out  1  loader accepts a bit this cycle
- `load_start`  in  1  single-cycle pulse: restart loading from word 0
- `addr`  in  ADDR_W  instruction address from CPU program counter
- `data`  out  DATA_W  instruction word `mem[addr]`
- `cpu_n_rst`  out  1  active-low reset to CPU, registered
- `loaded`  out  1  program complete, CPU running

## Operation
- States: `LOAD`, `HOLD`, `RUN`.
- `n_rst=0`: state `LOAD`, word pointer 0, bit counter 0, shift register 0, all memory words 0, `cpu_n_rst=0`, `loaded=0`, `ser_ready` reads 1 once out of reset.
- `LOAD`:
  - `ser_ready=1`, `data=0`.
  - A bit is accepted on each edge with `ser_valid&ser_ready`. The bit shifts in MSB-ward so the first bit lands in bit 0.
  - On the edge accepting bit `DATA_W-1` of a word, the assembled word is written to `mem[ptr]`, the bit counter clears and `ptr` increments.
  - If that word is word `N-1`, the next state is `HOLD`.
- `HOLD`: one cycle. `ser_ready=0`, `data=mem[addr]`, `cpu_n_rst=0`. Next state `RUN`; `cpu_n_rst` and `loaded` register to 1 on that edge.
- `RUN`: `ser_ready=0`, `data=mem[addr]` (combinational read), `cpu_n_rst=1`, `loaded=1`.
- `load_start=1` in any state: next state `LOAD`, `ptr=0`, bit counter 0, `cpu_n_rst` and `loaded` register to 0.
  - A bit offered on the same cycle is discarded, even in `LOAD`.
  - Memory is not cleared; old words remain until overwritten.
- `ser_valid` while `ser_ready=0`: ignored, no state change.
- Pointer width is `ADDR_W`; wrap from `N-1` never occurs because the loader leaves `LOAD` first.
- Bit counter width is `$clog2(DATA_W+1)`, which holds for `DATA_W=1`.

## Timing
- Load of a full program: exactly `N*DATA_W` accepted bits. Idle cycles between bits (`ser_valid=0`) are allowed.
- Last accepted bit at edge E: state `HOLD` after E; `cpu_n_rst=1` and `loaded=1` after E+1.
- The CPU therefore sees its first non-reset edge at E+2 with `addr=0` and `data=mem[0]`.
- `data` has zero latency from `addr`: the word is valid in the same cycle.
- `load_start` at edge E: `cpu_n_rst=0` after E; the first bit can be accepted at E+1.
- `n_rst` mid-load: all progress is lost and memory is zeroed on that edge. `n_rst` has priority over `load_start`.

## Structure
- The shared package (`cpu_pkg`) holds:
  - `loader_state_t` enum {`LD_LOAD`, `LD_HOLD`, `LD_RUN`}
  - default widths `CPU_ADDR_W=1`, `CPU_DATA_W=1`, which `cpu` also uses.
- Sub-module `prog_mem`: `N x DATA_W` register array with a synchronous write port (`we`, `waddr`, `wdata`), synchronous active-low clear, and an asynchronous read port.
- `prog_loader` contains the FSM, shift register, bit counter, pointer and output registers.

## Test plan
- Reset, then `ADDR_W=1`, `DATA_W=1`, bits 1,0 on consecutive cycles:
  - `ser_ready` stays 1 for 2 cycles.
  - `cpu_n_rst` rises 2 edges after the 2nd bit.
  - `addr=0` gives `data=1`; `addr=1` gives `data=0`.
- `DATA_W=4`, `ADDR_W=1`, bits 1,0,1,0 then 0,0,1,1 with random `ser_valid` gaps:
  - `mem[0]=4'h5`, `mem[1]=4'hC`.
  - `ser_ready` drops after exactly 8 accepted bits.
- Pulse `load_start` in `RUN` with `ser_valid=1` on the same cycle:
  - Next cycle `cpu_n_rst=0`, `loaded=0`, `ser_ready=1`.
  - The simultaneous bit is not counted.
  - Reloading 0,1 gives `data` 0/1 for `addr` 0/1.
- `load_start` after 1 of 2 bits in `LOAD`: the partial word is discarded; loading restarts at word 0 and still needs 2 more bits.
- Assert `n_rst=0` after 1 of 2 bits:
  - All outputs return to reset values and memory reads 0.
  - A new 2-bit load completes normally.
- `ser_valid=1` held throughout `HOLD`/`RUN`: no memory change and `loaded` stays 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU and its program loader.
// Holds the loader FSM state type and the default address/data widths
// used by both cpu and prog_loader.
package cpu_pkg;

    localparam int CPU_ADDR_W = 1;
    localparam int CPU_DATA_W = 1;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_HOLD,
        LD_RUN
    } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: N x DATA_W register array.
// Ports:
//   clk    - clock, all writes and clears on the rising edge
//   n_clr  - synchronous active-low clear of every word
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - asynchronous read address
//   rdata  - asynchronous read data, mem[raddr]
module prog_mem #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              n_clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [N];

    // Clear has priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (!n_clr) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: shifts a program in over a serial valid/ready port while
// holding the CPU in reset, then releases the CPU and serves instruction
// words combinationally.
// Ports:
//   clk        - clock
//   n_rst      - synchronous active-low reset (clears memory too)
//   ser_valid  - serial bit present
//   ser_bit    - serial bit, LSB of each word first, word 0 first
//   ser_ready  - loader accepts a bit this cycle (only while loading)
//   load_start - pulse: restart loading from word 0
//   addr       - instruction address from the CPU
//   data       - mem[addr] once loaded, 0 while loading
//   cpu_n_rst  - registered active-low CPU reset
//   loaded     - registered: program complete, CPU running
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ser_valid,
    input  logic              ser_bit,
    output logic              ser_ready,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              cpu_n_rst,
    output logic              loaded
);

    localparam int N     = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] next_word;
    logic [DATA_W-1:0] rdata;
    logic              accept;
    logic              last_bit;
    logic              mem_we;

    assign ser_ready = (state == LD_LOAD);

    // A bit offered alongside load_start is dropped.
    assign accept   = ser_valid & ser_ready & ~load_start;
    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign mem_we   = accept & last_bit;

    // New bit enters at the MSB and moves down, so after DATA_W bits the
    // first one sits in bit 0. Written as a shift/or so DATA_W=1 also works.
    assign next_word = (shreg >> 1) | (DATA_W'(ser_bit) << (DATA_W - 1));

    assign data = (state == LD_LOAD) ? '0 : rdata;

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .n_clr (n_rst),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (next_word),
        .raddr (addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= LD_LOAD;
            ptr       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cpu_n_rst <= 1'b0;
            loaded    <= 1'b0;
        end else if (load_start) begin
            state     <= LD_LOAD;
            ptr       <= '0;
            bit_cnt   <= '0;
            cpu_n_rst <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            unique case (state)
                LD_LOAD: begin
                    if (accept) begin
                        shreg <= next_word;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            ptr     <= ptr + ADDR_W'(1);
                            if (ptr == ADDR_W'(N - 1)) begin
                                state <= LD_HOLD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                LD_HOLD: begin
                    state     <= LD_RUN;
                    cpu_n_rst <= 1'b1;
                    loaded    <= 1'b1;
                end
                LD_RUN: begin
                end
                default: begin
                    state <= LD_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: one instance with 1-bit words and one with 4-bit
// words, each checked every cycle against a bit-count based reference model.
module tb_prog_loader;
    import cpu_pkg::*;

    logic       clk;
    logic       n_rst;
    logic       v1, b1, ls1, a1, r1, c1, l1, d1;
    logic       v4, b4, ls4, a4, r4, c4, l4;
    logic [3:0] d4;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: per instance, bits accepted since the last restart,
    // word under assembly, word storage, and whether an edge has passed
    // since the final bit.
    int dw [2] = '{1, 4};
    int m_bits  [2] = '{0, 0};
    int m_after [2] = '{0, 0};
    int m_cur   [2] = '{0, 0};
    int m_mem   [2][2] = '{'{0, 0}, '{0, 0}};

    prog_loader #(.ADDR_W(1), .DATA_W(1)) u1 (
        .clk(clk), .n_rst(n_rst), .ser_valid(v1), .ser_bit(b1), .ser_ready(r1),
        .load_start(ls1), .addr(a1), .data(d1), .cpu_n_rst(c1), .loaded(l1)
    );

    prog_loader #(.ADDR_W(1), .DATA_W(4)) u4 (
        .clk(clk), .n_rst(n_rst), .ser_valid(v4), .ser_bit(b4), .ser_ready(r4),
        .load_start(ls4), .addr(a4), .data(d4), .cpu_n_rst(c4), .loaded(l4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int d, input logic v, input logic b, input logic ls);
        int total;
        total = 2 * dw[d];
        if (!n_rst) begin
            m_bits[d] = 0; m_after[d] = 0; m_cur[d] = 0;
            m_mem[d][0] = 0; m_mem[d][1] = 0;
        end else if (ls) begin
            m_bits[d] = 0; m_after[d] = 0; m_cur[d] = 0;
        end else if (m_bits[d] < total) begin
            if (v) begin
                m_cur[d] = m_cur[d] | (int'(b) << (m_bits[d] % dw[d]));
                m_bits[d]++;
                if (m_bits[d] % dw[d] == 0) begin
                    m_mem[d][m_bits[d] / dw[d] - 1] = m_cur[d];
                    m_cur[d] = 0;
                end
            end
        end else begin
            m_after[d] = 1;
        end
    endtask

    task automatic cmp(input int d, input logic rdy, input logic cn, input logic ld,
                       input logic [3:0] dat, input logic ad);
        logic loading, run;
        int   exp_d;
        loading = (m_bits[d] < 2 * dw[d]);
        run     = !loading && (m_after[d] != 0);
        exp_d   = loading ? 0 : m_mem[d][ad];
        chk($sformatf("u%0d_ser_ready", dw[d]), 32'(rdy), 32'(loading));
        chk($sformatf("u%0d_cpu_n_rst", dw[d]), 32'(cn), 32'(run));
        chk($sformatf("u%0d_loaded", dw[d]), 32'(ld), 32'(run));
        chk($sformatf("u%0d_data", dw[d]), 32'(dat), 32'(exp_d));
    endtask

    always @(posedge clk) begin
        model_edge(0, v1, b1, ls1);
        model_edge(1, v4, b4, ls4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, r1, c1, l1, {3'b000, d1}, a1);
            cmp(1, r4, c4, l4, d4, a4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        n_rst = 0;
        v1 = 0; b1 = 0; ls1 = 0; a1 = 0;
        v4 = 0; b4 = 0; ls4 = 0; a4 = 0;
        step();
        chk_en = 1;
        step();
        chk("rst_ready1", 32'(r1), 32'd1);
        chk("rst_cpu_n_rst1", 32'(c1), 32'd0);
        chk("rst_loaded4", 32'(l4), 32'd0);
        n_rst = 1;

        // 1-bit words: program 1,0 on consecutive cycles
        v1 = 1; b1 = 1; step();
        chk("t1_ready_after_bit1", 32'(r1), 32'd1);
        b1 = 0; step();
        v1 = 0;
        chk("t1_ready_after_bit2", 32'(r1), 32'd0);
        chk("t1_hold_cpu_n_rst", 32'(c1), 32'd0);
        step();
        chk("t1_run_cpu_n_rst", 32'(c1), 32'd1);
        chk("t1_run_loaded", 32'(l1), 32'd1);
        a1 = 0; #1 chk("t1_data_a0", 32'(d1), 32'd1);
        a1 = 1; #1 chk("t1_data_a1", 32'(d1), 32'd0);
        chk("t1_model_mem0", 32'(m_mem[0][0]), 32'd1);

        // 4-bit words with random gaps: 1,0,1,0 then 0,0,1,1
        seq = 8'b1100_0101;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                v4 = 0; b4 = ~b4; step();
            end
            v4 = 1; b4 = seq[i]; step();
        end
        v4 = 0;
        chk("t2_ready_drop", 32'(r4), 32'd0);
        step(); step();
        chk("t2_loaded", 32'(l4), 32'd1);
        a4 = 0; #1 chk("t2_data_a0", 32'(d4), 32'h5);
        a4 = 1; #1 chk("t2_data_a1", 32'(d4), 32'hC);
        chk("t2_model_mem0", 32'(m_mem[1][0]), 32'h5);
        chk("t2_model_mem1", 32'(m_mem[1][1]), 32'hC);

        // load_start in RUN with a bit offered on the same cycle
        ls1 = 1; v1 = 1; b1 = 1; step();
        ls1 = 0; v1 = 0;
        chk("t3_cpu_n_rst", 32'(c1), 32'd0);
        chk("t3_loaded", 32'(l1), 32'd0);
        chk("t3_ready", 32'(r1), 32'd1);
        v1 = 1; b1 = 0; step();
        b1 = 1; step();
        v1 = 0;
        chk("t3_ready_done", 32'(r1), 32'd0);
        step(); step();
        a1 = 0; #1 chk("t3_data_a0", 32'(d1), 32'd0);
        a1 = 1; #1 chk("t3_data_a1", 32'(d1), 32'd1);

        // load_start after one of two bits in LOAD
        ls1 = 1; step();
        ls1 = 0; v1 = 1; b1 = 0; step();
        ls1 = 1; b1 = 0; step();
        ls1 = 0; b1 = 1; step();
        chk("t4_ready_mid", 32'(r1), 32'd1);
        b1 = 0; step();
        v1 = 0;
        chk("t4_ready_done", 32'(r1), 32'd0);
        step(); step();
        a1 = 0; #1 chk("t4_data_a0", 32'(d1), 32'd1);
        a1 = 1; #1 chk("t4_data_a1", 32'(d1), 32'd0);

        // n_rst after one of two bits, with load_start also high
        ls1 = 1; step();
        ls1 = 0; v1 = 1; b1 = 1; step();
        v1 = 0; n_rst = 0; ls1 = 1; step();
        ls1 = 0;
        chk("t5_cpu_n_rst", 32'(c1), 32'd0);
        chk("t5_loaded", 32'(l1), 32'd0);
        chk("t5_ready", 32'(r1), 32'd1);
        chk("t5_loaded4", 32'(l4), 32'd0);
        chk("t5_model_mem4", 32'(m_mem[1][0]), 32'd0);
        n_rst = 1;
        v1 = 1; b1 = 1; step();
        step();
        v1 = 0; step(); step();
        chk("t5_loaded_again", 32'(l1), 32'd1);
        a1 = 0; #1 chk("t5_data_a0", 32'(d1), 32'd1);
        a1 = 1; #1 chk("t5_data_a1", 32'(d1), 32'd1);

        // ser_valid held high through HOLD and RUN
        ls1 = 1; step();
        ls1 = 0; v1 = 1; b1 = 0; step();
        b1 = 1; step();
        for (int i = 0; i < 6; i++) begin
            b1 = ~b1; step();
        end
        chk("t6_loaded", 32'(l1), 32'd1);
        a1 = 0; #1 chk("t6_data_a0", 32'(d1), 32'd0);
        a1 = 1; #1 chk("t6_data_a1", 32'(d1), 32'd1);
        v1 = 0;
        step(); step();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
